ctrl_unit_4bit: RTL and testbench
=================================

Name: ctrl_unit_4bit

Overview:
Multi-cycle control unit that drives the control word of dat_proc_unit_4bit and consumes its V/C/N/Z flags. It fetches 16-bit instructions from an external instruction ROM and decodes them into the datapath select/load signals. It latches the datapath status flags and resolves conditional branches. With the datapath it forms the 4-bit CPU.

Parameters:
PC_W, 8, program counter / instruction address width (address space 2^PC_W words)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
instr_data  input  16  instruction word at instr_addr, valid combinationally in the same cycle
instr_addr  output  PC_W  instruction fetch address (= pc)
V, C, N, Z  input  1 each  datapath status flags
load_enable  output  1  register-file write enable
A_select, B_select, D_select  output  2 each  source A, source B, destination register
H_select  output  2  shifter op: 00 pass, 01 shift right, 10 shift left
G_select  output  4  ALU function code
MB_select  output  1  1 = constant_input onto B path
MF_select  output  1  1 = shifter result, 0 = ALU result
MD_select  output  1  1 = data_input to register file
constant_input  output  4  immediate field
halted  output  1  high once HLT has executed

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Instruction format: [15:12] opcode, [11:10] DR, [9:8] SA, [7:6] SB, [5:4] reserved (ignored), [3:0] imm.
- FSM states: FETCH, EXECUTE, HALT.
  - FETCH -> EXECUTE always.
  - EXECUTE -> HALT on HLT; otherwise EXECUTE -> FETCH.
  - HALT is held until rst.
- FETCH: IR <= instr_data; pc <= pc+1, wrapping modulo 2^PC_W (255 -> 0). All control outputs are 0.
- EXECUTE: control outputs are decoded combinationally from IR.
  - A_select=SA, B_select=SB, D_select=DR, constant_input=imm.
  - load_enable=1 for write opcodes only.
  - Each instruction takes 2 cycles.
- Opcodes:
  - 0 NOP: no write.
  - 1 MOV: G=G_TFA.
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT: G = matching code, MB=0, MF=0.
  - 8 ADI: G_ADD, MB=1.
  - 9 LDI: MB=1, MF=1, H=00.
  - A SHL: MF=1, H=10.
  - B SHR: MF=1, H=01.
  - C LD: MD=1.
  - D BRZ, E BRN: no write.
  - F HLT.
- Flag register: {V,C,N,Z} is captured at the end of EXECUTE for opcodes 1–B. LD, NOP, branches and HLT leave it unchanged.
- Branches: if the latched Z (BRZ) or latched N (BRN) is 1, pc <= pc + sign_extend(imm), where pc already points at the next instruction.
  - Range is −8..+7, wrapping modulo 2^PC_W.
  - Not taken: pc unchanged.
- HALT: halted=1 from the cycle after the HLT EXECUTE. pc is frozen and all control outputs are 0.
- Reset values: state=FETCH, pc=0, IR=0, flags=0, halted=0, all control outputs 0.
- load_enable is forced to 0 while rst=1, including a reset asserted mid-EXECUTE, so no register write occurs on that edge.
- The reserved field and unused fields per opcode are don't-care inputs. Outputs for unused fields still follow the IR fields but have no effect.

Decomposition:
- Package ctrl_pkg_4bit holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - G codes: G_TFA=0000, G_ADD=0010, G_SUB=0101, G_AND=1000, G_OR=1010, G_XOR=1100, G_NOT=1110;
  - H codes;
  - state encoding.
- One sub-module, ctrl_decode_4bit: purely combinational IR -> control word. The FSM, pc, IR and flag register stay in ctrl_unit_4bit.

Test Plan:
- Reset: rst=1 for 2 cycles -> pc=0, instr_addr=0, halted=0, load_enable=0, all selects 0.
- LDI R1,5 (0x9405) at addr 0 -> in the EXECUTE cycle: load_enable=1, D_select=01, MB=1, MF=1, H=00, constant_input=0101; pc=1.
- ADD R2,R1,R1 (0x2940) with Z=1 driven during EXECUTE -> D=10, A=01, B=01, G=0010, MB=MF=MD=0, load_enable=1; latched Z=1.
- BRZ −2 (0xD00E) at addr 5 -> taken when latched Z=1: pc=4; not taken when latched Z=0: pc=6.
- HLT (0xF000) -> halted=1 next cycle; pc frozen and load_enable=0 for 10+ cycles; rst restores pc=0, halted=0.
- Edge cases:
  - rst asserted during ADD EXECUTE -> load_enable=0 that cycle, no flag capture.
  - FETCH at pc=255 -> pc=0.

Source files
------------

// File: rtl/ctrl_unit_4bit_pkg.sv
// Shared definitions for the 4-bit CPU control unit: opcodes, datapath
// function codes, FSM encoding and the decoded control word.
package ctrl_pkg_4bit;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_ADI = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_LD  = 4'hC;
  localparam logic [3:0] OP_BRZ = 4'hD;
  localparam logic [3:0] OP_BRN = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] G_TFA = 4'b0000;
  localparam logic [3:0] G_ADD = 4'b0010;
  localparam logic [3:0] G_SUB = 4'b0101;
  localparam logic [3:0] G_AND = 4'b1000;
  localparam logic [3:0] G_OR  = 4'b1010;
  localparam logic [3:0] G_XOR = 4'b1100;
  localparam logic [3:0] G_NOT = 4'b1110;

  localparam logic [1:0] H_PASS = 2'b00;
  localparam logic [1:0] H_SHR  = 2'b01;
  localparam logic [1:0] H_SHL  = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_EXECUTE = 2'b01,
    ST_HALT    = 2'b10
  } state_t;

  typedef struct packed {
    logic       load_enable;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [1:0] d_sel;
    logic [1:0] h_sel;
    logic [3:0] g_sel;
    logic       mb;
    logic       mf;
    logic       md;
    logic [3:0] const_in;
  } ctrl_word_t;

  // Only datapath-computing instructions (MOV..SHR) update the status flags.
  function automatic logic writes_flags(input logic [3:0] op);
    return (op >= OP_MOV) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/ctrl_unit_4bit_decode.sv
// Combinational instruction decoder: IR -> datapath control word.
// Unused fields still pass straight through to the selects.
module ctrl_decode_4bit
  import ctrl_pkg_4bit::*;
(
  input  logic [15:0] ir,
  output ctrl_word_t  cw
);

  logic [3:0] op;
  logic       unused_reserved;

  assign op              = ir[15:12];
  assign unused_reserved = ^ir[5:4];

  // Field routing plus per-opcode function/mux selection
  always_comb begin
    cw          = '0;
    cw.d_sel    = ir[11:10];
    cw.a_sel    = ir[9:8];
    cw.b_sel    = ir[7:6];
    cw.const_in = ir[3:0];
    case (op)
      OP_NOP: cw.load_enable = 1'b0;
      OP_MOV: begin cw.load_enable = 1'b1; cw.g_sel = G_TFA; end
      OP_ADD: begin cw.load_enable = 1'b1; cw.g_sel = G_ADD; end
      OP_SUB: begin cw.load_enable = 1'b1; cw.g_sel = G_SUB; end
      OP_AND: begin cw.load_enable = 1'b1; cw.g_sel = G_AND; end
      OP_OR:  begin cw.load_enable = 1'b1; cw.g_sel = G_OR;  end
      OP_XOR: begin cw.load_enable = 1'b1; cw.g_sel = G_XOR; end
      OP_NOT: begin cw.load_enable = 1'b1; cw.g_sel = G_NOT; end
      OP_ADI: begin cw.load_enable = 1'b1; cw.g_sel = G_ADD; cw.mb = 1'b1; end
      OP_LDI: begin
        cw.load_enable = 1'b1;
        cw.mb          = 1'b1;
        cw.mf          = 1'b1;
        cw.h_sel       = H_PASS;
      end
      OP_SHL: begin cw.load_enable = 1'b1; cw.mf = 1'b1; cw.h_sel = H_SHL; end
      OP_SHR: begin cw.load_enable = 1'b1; cw.mf = 1'b1; cw.h_sel = H_SHR; end
      OP_LD:  begin cw.load_enable = 1'b1; cw.md = 1'b1; end
      OP_BRZ, OP_BRN, OP_HLT: cw.load_enable = 1'b0;
      default: cw.load_enable = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_4bit.sv
// Multi-cycle FETCH/EXECUTE control unit for the 4-bit CPU: owns pc, IR,
// the latched status flags and branch resolution.
module ctrl_unit_4bit
  import ctrl_pkg_4bit::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     instr_data,
  output logic [PC_W-1:0] instr_addr,
  input  logic            V,
  input  logic            C,
  input  logic            N,
  input  logic            Z,
  output logic            load_enable,
  output logic [1:0]      A_select,
  output logic [1:0]      B_select,
  output logic [1:0]      D_select,
  output logic [1:0]      H_select,
  output logic [3:0]      G_select,
  output logic            MB_select,
  output logic            MF_select,
  output logic            MD_select,
  output logic [3:0]      constant_input,
  output logic            halted
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic [15:0]     ir;
  logic [3:0]      flags;
  logic            halt_flag;
  logic [3:0]      opcode;
  logic [PC_W-1:0] branch_offset;
  logic            branch_taken;
  ctrl_word_t      dec_word;
  ctrl_word_t      cw;
  logic            unused_flags;

  ctrl_decode_4bit u_decode (
    .ir (ir),
    .cw (dec_word)
  );

  assign opcode        = ir[15:12];
  assign branch_offset = {{(PC_W-4){ir[3]}}, ir[3:0]};
  // flags holds {V,C,N,Z}; only N and Z steer branches
  assign branch_taken  = ((opcode == OP_BRZ) && flags[0]) ||
                         ((opcode == OP_BRN) && flags[1]);
  assign unused_flags  = ^flags[3:2];

  // Next-state, next-pc and the gated control word
  always_comb begin
    state_next = state;
    pc_next    = pc;
    cw         = '0;
    case (state)
      ST_FETCH: begin
        state_next = ST_EXECUTE;
        pc_next    = pc + PC_ONE;
      end
      ST_EXECUTE: begin
        if (opcode == OP_HLT) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_FETCH;
        end
        if (branch_taken) begin
          pc_next = pc + branch_offset;
        end else begin
          pc_next = pc;
        end
        // A reset landing mid-EXECUTE must not commit a register write
        if (rst) begin
          cw = '0;
        end else begin
          cw = dec_word;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  // State, pc, IR, flag register and halt indicator
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc        <= '0;
      ir        <= 16'h0000;
      flags     <= 4'b0000;
      halt_flag <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == ST_FETCH) begin
        ir <= instr_data;
      end
      if ((state == ST_EXECUTE) && writes_flags(opcode)) begin
        flags <= {V, C, N, Z};
      end
      if ((state == ST_EXECUTE) && (opcode == OP_HLT)) begin
        halt_flag <= 1'b1;
      end
    end
  end

  assign instr_addr     = pc;
  assign halted         = halt_flag;
  assign load_enable    = cw.load_enable;
  assign A_select       = cw.a_sel;
  assign B_select       = cw.b_sel;
  assign D_select       = cw.d_sel;
  assign H_select       = cw.h_sel;
  assign G_select       = cw.g_sel;
  assign MB_select      = cw.mb;
  assign MF_select      = cw.mf;
  assign MD_select      = cw.md;
  assign constant_input = cw.const_in;

endmodule

// File: tb/tb_ctrl_unit_4bit.sv
// Scoreboard bench for ctrl_unit_4bit: an instruction-level reference model
// predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_ctrl_unit_4bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_data;
  logic [7:0]  instr_addr;
  logic        V, C, N, Z;
  logic        load_enable, MB_select, MF_select, MD_select, halted;
  logic [1:0]  A_select, B_select, D_select, H_select;
  logic [3:0]  G_select, constant_input;

  logic [15:0] rom [256];
  assign instr_data = rom[instr_addr];

  always #5 clk = ~clk;

  ctrl_unit_4bit #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .instr_data(instr_data), .instr_addr(instr_addr),
    .V(V), .C(C), .N(N), .Z(Z), .load_enable(load_enable),
    .A_select(A_select), .B_select(B_select), .D_select(D_select),
    .H_select(H_select), .G_select(G_select), .MB_select(MB_select),
    .MF_select(MF_select), .MD_select(MD_select),
    .constant_input(constant_input), .halted(halted)
  );

  typedef struct {
    logic [28:0] v;
    int          cyc;
  } item_t;

  item_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  // Spec tables per opcode
  logic [3:0] g_tab  [16];
  logic [1:0] h_tab  [16];
  logic       mb_tab [16];
  logic       mf_tab [16];
  logic       md_tab [16];

  // Instruction-level reference state: phase 0 fetch, 1 execute, 2 halted
  int          m_phase;
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [3:0]  m_flags;
  logic        m_halted;
  bit          m_known = 1'b0;

  function automatic logic [28:0] model_out(input logic r);
    logic [3:0]  op;
    logic [19:0] ctl;
    int          k;
    op  = m_ir[15:12];
    k   = int'(op);
    ctl = 20'h00000;
    if (!r && m_phase == 1) begin
      ctl = {(k >= 1 && k <= 12), m_ir[9:8], m_ir[7:6], m_ir[11:10],
             h_tab[k], g_tab[k], mb_tab[k], mf_tab[k], md_tab[k], m_ir[3:0]};
    end
    return {m_pc, m_halted, ctl};
  endfunction

  task automatic model_advance(input logic r, input logic [3:0] f);
    int k;
    if (r) begin
      m_phase = 0; m_pc = 8'd0; m_ir = 16'h0000; m_flags = 4'b0000;
      m_halted = 1'b0; m_known = 1'b1;
    end else if (m_phase == 0) begin
      m_ir    = rom[m_pc];
      m_pc    = m_pc + 8'd1;
      m_phase = 1;
    end else if (m_phase == 1) begin
      k = int'(m_ir[15:12]);
      if ((k == 13 && m_flags[0]) || (k == 14 && m_flags[1]))
        m_pc = m_pc + {{4{m_ir[3]}}, m_ir[3:0]};
      if (k >= 1 && k <= 11) m_flags = f;
      if (k == 15) begin
        m_phase = 2; m_halted = 1'b1;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] f);
    item_t it;
    rst = r;
    {V, C, N, Z} = f;
    if (m_known) begin
      it.v   = model_out(r);
      it.cyc = cyc;
      q.push_back(it);
    end
    model_advance(r, f);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: one prediction per cycle, compared mid-cycle
  always @(negedge clk) begin
    item_t       it;
    logic [28:0] act;
    if (q.size() > 0) begin
      it  = q.pop_front();
      act = {instr_addr, halted, load_enable, A_select, B_select, D_select,
             H_select, G_select, MB_select, MF_select, MD_select, constant_input};
      n_checks++;
      if (act !== it.v) begin
        n_fail++;
        $display("FAIL cycle %0d ctrl_word: got %h expected %h (addr got %h exp %h)",
                 it.cyc, act, it.v, act[28:21], it.v[28:21]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      g_tab[i] = 4'b0000; h_tab[i] = 2'b00;
      mb_tab[i] = 1'b0; mf_tab[i] = 1'b0; md_tab[i] = 1'b0;
    end
    g_tab[2] = 4'b0010; g_tab[3] = 4'b0101; g_tab[4] = 4'b1000;
    g_tab[5] = 4'b1010; g_tab[6] = 4'b1100; g_tab[7] = 4'b1110;
    g_tab[8] = 4'b0010; mb_tab[8] = 1'b1;
    mb_tab[9] = 1'b1; mf_tab[9] = 1'b1;
    mf_tab[10] = 1'b1; h_tab[10] = 2'b10;
    mf_tab[11] = 1'b1; h_tab[11] = 2'b01;
    md_tab[12] = 1'b1;

    // Directed program: LDI, ADD, forward/backward branches, HLT
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h9405; rom[1] = 16'h2940; rom[2] = 16'hD002;
    rom[3] = 16'h0000; rom[4] = 16'h6940; rom[5] = 16'hD00E;
    rom[6] = 16'hF000;
    rst = 1'b1; {V, C, N, Z} = 4'b0000;
    #1;
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    for (int k = 0; k < 40; k++) step(1'b0, (k == 3) ? 4'b0001 : 4'b0000);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);

    // Reset asserted during ADD execute
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0000);
    step(1'b1, 4'b1111);
    step(1'b1, 4'b0000);
    for (int k = 0; k < 8; k++) step(1'b0, 4'($urandom));

    // All-NOP sweep so pc wraps 255 -> 0
    for (int i = 0; i < 256; i++) rom[i] = {4'h0, 12'($urandom)};
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    for (int k = 0; k < 520; k++) step(1'b0, 4'($urandom));

    // Random program, random flags, occasional reset
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    step(1'b1, 4'b0000);
    for (int k = 0; k < 1500; k++)
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, 4'($urandom));

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
